// File: rtl/riscv_ras_stack.sv
// riscv_ras_stack: return-address stack storage with checkpoint/restore for control speculation
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_pop/i_pop_then_push stack
// strobes; i_ret_addr address to store; i_ckpt_save/i_ckpt_restore pointer snapshot control;
// o_top_valid/o_top_addr predicted return target; o_ras_addr zero-extended occupancy;
// o_overflow/o_underflow one-cycle error pulses.
// Build option RAS_OVERFLOW_WRAP_EN: a push while full overwrites the oldest entry circularly.
module riscv_ras_stack #(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_pop_then_push,
  input  logic [ADDR_WIDTH-1:0] i_ret_addr,
  input  logic                  i_ckpt_save,
  input  logic                  i_ckpt_restore,
  output logic                  o_top_valid,
  output logic [ADDR_WIDTH-1:0] o_top_addr,
  output logic [ADDR_WIDTH-1:0] o_ras_addr,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
`ifdef RAS_OVERFLOW_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, ckpt_ptr, top_idx, ptr_nx;
  logic [CW-1:0] cnt, ckpt_cnt, cnt_nx;
  logic empty, full, do_push, do_rep, do_pop, wr_push;
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(RAS_DEPTH);
  assign top_idx = ptr - 1'b1;
  // pop-then-push on an empty stack degrades to a plain push
  assign do_push = !i_ckpt_restore && (i_pop_then_push ? empty : i_push);
  assign do_rep  = !i_ckpt_restore && i_pop_then_push && !empty;
  assign do_pop  = !i_ckpt_restore && !i_pop_then_push && !i_push && i_pop;
  assign wr_push = do_push && (!full || WRAP);
  always_comb begin
    ptr_nx = i_ckpt_restore ? ckpt_ptr : wr_push ? ptr + 1'b1 : (do_pop && !empty) ? ptr - 1'b1 : ptr;
    cnt_nx = i_ckpt_restore ? ckpt_cnt : (do_push && !full) ? cnt + 1'b1 : (do_pop && !empty) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      ptr         <= '0;
      cnt         <= '0;
      ckpt_ptr    <= '0;
      ckpt_cnt    <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      ptr         <= ptr_nx;
      cnt         <= cnt_nx;
      o_overflow  <= do_push && full;
      o_underflow <= do_pop && empty;
      if (i_ckpt_save && !i_ckpt_restore) begin
        ckpt_ptr <= ptr;
        ckpt_cnt <= cnt;
      end
    end
  always_ff @(posedge i_clk)
    if (wr_push) mem[ptr] <= i_ret_addr;
    else if (do_rep) mem[top_idx] <= i_ret_addr;
  assign o_top_valid = !empty;
  assign o_top_addr  = empty ? '0 : mem[top_idx];
  assign o_ras_addr  = ADDR_WIDTH'(cnt);
endmodule

// File: tb/tb_riscv_ras_stack.sv
// tb_riscv_ras_stack: directed table-driven checks of the return-address stack
module tb_riscv_ras_stack;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_push = 1'b0, i_pop = 1'b0, i_pop_then_push = 1'b0, i_ckpt_save = 1'b0, i_ckpt_restore = 1'b0;
  logic [63:0] i_ret_addr = '0;
  logic o_top_valid, o_overflow, o_underflow;
  logic [63:0] o_top_addr, o_ras_addr;
  int errs = 0, checks = 0;
  typedef struct {
    logic pu, po, pp;
    logic [63:0] a;
    logic sv, rs, ev;
    logic [63:0] etop;
    int ecnt;
    logic eov, eun;
  } vec_t;
  vec_t vt[14];
  riscv_ras_stack #(.ADDR_WIDTH(64), .RAS_DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(i_push), .i_pop(i_pop),
    .i_pop_then_push(i_pop_then_push), .i_ret_addr(i_ret_addr),
    .i_ckpt_save(i_ckpt_save), .i_ckpt_restore(i_ckpt_restore),
    .o_top_valid(o_top_valid), .o_top_addr(o_top_addr), .o_ras_addr(o_ras_addr),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic expect_st(input string n, input logic v, input logic [63:0] top, input int c, input logic ov, input logic un);
    chk({n, ".valid"}, 64'(o_top_valid), 64'(v));
    chk({n, ".top"}, o_top_addr, top);
    chk({n, ".cnt"}, o_ras_addr, 64'(c));
    chk({n, ".ovf"}, 64'(o_overflow), 64'(ov));
    chk({n, ".udf"}, 64'(o_underflow), 64'(un));
  endtask
  task automatic step(input logic pu, input logic po, input logic pp, input logic [63:0] a, input logic sv, input logic rs);
    i_push = pu; i_pop = po; i_pop_then_push = pp; i_ret_addr = a; i_ckpt_save = sv; i_ckpt_restore = rs;
    @(posedge i_clk);
    #1;
    i_push = 0; i_pop = 0; i_pop_then_push = 0; i_ret_addr = '0; i_ckpt_save = 0; i_ckpt_restore = 0;
  endtask
  initial begin
    vt[0]  = '{1, 0, 0, 64'h1000, 0, 0, 1, 64'h1000, 1, 0, 0};
    vt[1]  = '{1, 0, 0, 64'h2000, 0, 0, 1, 64'h2000, 2, 0, 0};
    vt[2]  = '{0, 1, 0, 64'h0,    0, 0, 1, 64'h1000, 1, 0, 0};
    vt[3]  = '{0, 1, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 0};
    vt[4]  = '{0, 1, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 1};
    vt[5]  = '{0, 0, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 0};
    vt[6]  = '{1, 0, 0, 64'hA0,   0, 0, 1, 64'hA0,   1, 0, 0};
    vt[7]  = '{0, 0, 1, 64'hB0,   0, 0, 1, 64'hB0,   1, 0, 0};
    vt[8]  = '{0, 1, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 0};
    vt[9]  = '{0, 0, 1, 64'hC0,   0, 0, 1, 64'hC0,   1, 0, 0};
    vt[10] = '{0, 1, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 0};
    vt[11] = '{1, 1, 0, 64'h55,   0, 0, 1, 64'h55,   1, 0, 0};
    vt[12] = '{1, 0, 1, 64'h66,   0, 0, 1, 64'h66,   1, 0, 0};
    vt[13] = '{0, 1, 0, 64'h0,    0, 0, 0, 64'h0,    0, 0, 0};
    #12;
    expect_st("reset", 0, 64'h0, 0, 0, 0);
    i_rst_n = 1'b1;
    foreach (vt[k]) begin
      step(vt[k].pu, vt[k].po, vt[k].pp, vt[k].a, vt[k].sv, vt[k].rs);
      expect_st($sformatf("vec%0d", k), vt[k].ev, vt[k].etop, vt[k].ecnt, vt[k].eov, vt[k].eun);
    end
    for (int i = 0; i < 16; i++) step(1, 0, 0, 64'h10 + 64'(i), 0, 0);
    expect_st("full", 1, 64'h1F, 16, 0, 0);
    step(1, 0, 0, 64'h99, 0, 0);
`ifdef RAS_OVERFLOW_WRAP_EN
    expect_st("ovf_push", 1, 64'h99, 16, 1, 0);
`else
    expect_st("ovf_push", 1, 64'h1F, 16, 1, 0);
`endif
    step(0, 0, 0, 64'h0, 0, 0);
    expect_st("ovf_clear", 1, o_top_addr, 16, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      logic [63:0] e;
`ifdef RAS_OVERFLOW_WRAP_EN
      e = (i == 16) ? 64'h0 : 64'h20 - 64'(i);
`else
      e = (i == 16) ? 64'h0 : 64'h1F - 64'(i);
`endif
      step(0, 1, 0, 64'h0, 0, 0);
      expect_st($sformatf("drain%0d", i), i != 16, e, 16 - i, 0, 0);
    end
    step(1, 0, 0, 64'h100, 0, 0);
    step(0, 0, 0, 64'h0, 1, 0);
    step(1, 0, 0, 64'h200, 0, 0);
    step(1, 0, 0, 64'h300, 0, 0);
    expect_st("pre_restore", 1, 64'h300, 3, 0, 0);
    step(1, 0, 0, 64'h400, 0, 1);
    expect_st("restore", 1, 64'h100, 1, 0, 0);
    step(1, 0, 0, 64'h500, 1, 0);
    expect_st("save_push", 1, 64'h500, 2, 0, 0);
    step(1, 0, 0, 64'h600, 0, 0);
    step(0, 0, 0, 64'h0, 0, 1);
    expect_st("restore2", 1, 64'h100, 1, 0, 0);
    step(0, 1, 0, 64'h0, 0, 0);
    step(1, 0, 0, 64'h1, 0, 0);
    step(1, 0, 0, 64'h2, 0, 0);
    step(1, 0, 0, 64'h3, 0, 0);
    expect_st("pre_reset", 1, 64'h3, 3, 0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    expect_st("async_reset", 0, 64'h0, 0, 0, 0);
    #3;
    i_rst_n = 1'b1;
    step(0, 0, 0, 64'h0, 0, 1);
    expect_st("ckpt_cleared", 0, 64'h0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/riscv_ras_stack.md
Name: riscv_ras_stack

Overview:
- Return-address stack storage, directly downstream of the RAS control logic in the control-speculation unit.
- Consumes the push, pop and pop-then-push strobes from the control logic and the return address computed in EX.
- Produces the predicted return target for fetch.
- Feeds its occupancy count back to the control logic as the RAS address input.

Parameters:
ADDR_WIDTH, 64, width of stored return addresses and of the fed-back count port
RAS_DEPTH, 16, number of stack entries (power of two, >= 2)

Ports:
i_clk  input  1  core clock
i_rst_n  input  1  asynchronous active-low reset
i_push  input  1  push strobe from RAS control logic
i_pop  input  1  pop strobe from RAS control logic
i_pop_then_push  input  1  replace-top strobe from RAS control logic
i_ret_addr  input  ADDR_WIDTH  return address to store (link PC + 4)
i_ckpt_save  input  1  snapshot pointer/count (branch issue)
i_ckpt_restore  input  1  restore snapshot (mispredict flush)
o_top_valid  output  1  stack non-empty
o_top_addr  output  ADDR_WIDTH  predicted return address (top entry)
o_ras_addr  output  ADDR_WIDTH  zero-extended occupancy count, fed back to control logic
o_overflow  output  1  one-cycle pulse: push while full
o_underflow  output  1  one-cycle pulse: pop while empty

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low on i_rst_n.
- State:
  - mem[RAS_DEPTH] x ADDR_WIDTH; entries are not reset.
  - ptr: $clog2(RAS_DEPTH) bits, next free slot.
  - cnt: $clog2(RAS_DEPTH)+1 bits, 0..RAS_DEPTH.
  - ckpt_ptr, ckpt_cnt snapshot registers.
- Reset values: ptr=0, cnt=0, ckpt_ptr=0, ckpt_cnt=0, o_overflow=0, o_underflow=0. This gives o_top_valid=0, o_top_addr=0, o_ras_addr=0.
- Outputs:
  - o_top_valid = (cnt!=0).
  - o_top_addr = mem[ptr-1] (modulo RAS_DEPTH) when cnt!=0, else 0. Combinational from registers, so an update is visible the cycle after the strobe.
  - o_ras_addr = {zeros, cnt}.
- Command priority per cycle: i_ckpt_restore > i_pop_then_push > i_push > i_pop. Only the highest active command takes effect.
- Push, cnt<RAS_DEPTH: mem[ptr]<=i_ret_addr; ptr<=ptr+1 (wraps); cnt<=cnt+1.
- Push, cnt==RAS_DEPTH: no state change; o_overflow pulses for 1 cycle (see Optional Feature).
- Pop, cnt>0: ptr<=ptr-1 (wraps); cnt<=cnt-1. Entry contents are unchanged.
- Pop, cnt==0: no state change; o_underflow pulses for 1 cycle.
- Pop-then-push, cnt>0: mem[ptr-1]<=i_ret_addr; ptr and cnt unchanged.
- Pop-then-push, cnt==0: behaves as push.
- Checkpoint save: ckpt_ptr<=ptr and ckpt_cnt<=cnt, sampled pre-update; this happens in parallel with any push/pop in the same cycle.
- Checkpoint restore: ptr<=ckpt_ptr, cnt<=ckpt_cnt. All push/pop strobes and i_ckpt_save are ignored that cycle. Entry contents are not restored; stale data is an acceptable mispredict.
- Latency: a single-cycle update for every command.
- Reset mid-operation: all state listed above returns to its reset value immediately (asynchronous).

Optional Feature:
Macro RAS_OVERFLOW_WRAP_EN.
- Defined: push at cnt==RAS_DEPTH writes mem[ptr] and does ptr<=ptr+1, overwriting the oldest entry circularly. cnt stays at RAS_DEPTH and o_overflow still pulses.
- Undefined: push while full is dropped, as specified in Behaviour.

Test Plan:
- Reset, then push 0x1000, 0x2000 on consecutive cycles -> o_top_addr=0x2000, o_ras_addr=2, o_top_valid=1.
- Continue from the previous scenario, then pop twice -> o_top_addr 0x1000 then 0 with o_top_valid=0. A third pop -> o_underflow=1 for one cycle, cnt stays 0.
- Push 0xA0, then pop_then_push 0xB0 -> o_top_addr=0xB0, o_ras_addr=1. Pop_then_push on an empty stack with 0xC0 -> cnt=1, top=0xC0.
- Push 16 addresses 0x10..0x1F, then push 0x99:
  - Without RAS_OVERFLOW_WRAP_EN: top=0x1F, o_overflow pulses.
  - With RAS_OVERFLOW_WRAP_EN: top=0x99 and cnt=16; 16 pops return 0x99, 0x1F..0x11.
- Push 0x100, ckpt_save, push 0x200, push 0x300, ckpt_restore with i_push active -> cnt=1, top=0x100, push ignored.
- Push 3 entries, then assert i_rst_n=0 asynchronously mid-cycle -> o_top_valid=0, o_ras_addr=0 before the next clock edge.
